eu_register_file: RTL and testbench
===================================

# eu_register_file

Register file feeding the execution unit's arithmetic stage. It holds 2**ADDR_WIDTH general-purpose registers of BUS_WIDTH bits. Two read ports produce registered operands A_out/B_out, which connect to the arithmetic unit's A/B inputs. One write port captures the arithmetic unit's data_out for writeback.

## Interface
- BUS_WIDTH, 16, width of every register and data port
- ADDR_WIDTH, 3, register address width; DEPTH = 2**ADDR_WIDTH registers (8 by default)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write enable for the writeback port
- wr_addr  input  ADDR_WIDTH  destination register
- wr_data  input  BUS_WIDTH  writeback data (from arithmetic unit data_out)
- rd_en  input  1  operand fetch enable; when low, A_out/B_out hold
- addr_a  input  ADDR_WIDTH  source register for operand A
- addr_b  input  ADDR_WIDTH  source register for operand B
- mb_select  input  1  1: B operand taken from const_in instead of the register file
- const_in  input  BUS_WIDTH  immediate operand
- A_out  output  BUS_WIDTH  registered operand A (to arithmetic A)
- B_out  output  BUS_WIDTH  registered operand B (to arithmetic B)
- rd_valid  output  1  high for exactly one cycle after each cycle with rd_en=1

## Operation
- Reset (rst_n=0, asynchronous assert): all DEPTH registers = 0, A_out = 0, B_out = 0, rd_valid = 0. Takes effect immediately, including mid-write or mid-read; the write in that cycle is discarded.
- Reset release is synchronous in effect: the first state update happens on the first rising edge with rst_n=1.
- Write: on rising edge with wr_en=1, regs[wr_addr] <= wr_data. With wr_en=0, no register changes.
- Read, on rising edge with rd_en=1:
  - A_out <= regs[addr_a]
  - B_out <= mb_select ? const_in : regs[addr_b]
  - rd_valid <= 1
- On rising edge with rd_en=0: A_out and B_out hold; rd_valid <= 0.
- addr_a == addr_b is legal; both outputs return the same register.
- No register is hardwired; register 0 is writable like any other.
- All addresses in range by construction (full ADDR_WIDTH decode); no wrap or error condition.
- Pure data movement: no arithmetic, no truncation. Widths of const_in, wr_data and registers are identical.

## Timing
- Write latency: data written at edge N is readable by a rd_en fetch at edge N+1, so it is visible on A_out/B_out after edge N+1.
- Read latency: 1 cycle. Addresses sampled at edge N appear on A_out/B_out, with rd_valid=1, after edge N.
- Simultaneous write and read of the same address at the same edge: see Configuration.
- Back-to-back fetches: a new operand pair on every cycle with rd_en=1; rd_valid stays high continuously.
- No combinational path from any input to any output.

## Configuration
- WRITE_BYPASS_EN defined:
  - On an edge with wr_en=1, rd_en=1 and wr_addr equal to addr_a, A_out <= wr_data (the new value).
  - The same applies to B_out when wr_addr equals addr_b and mb_select=0.
  - Lets a dependent instruction issue in the cycle directly after its producer.
- WRITE_BYPASS_EN undefined:
  - In the same collision, the read returns the pre-write register contents.
  - The write still completes.
  - A dependent instruction must wait one cycle.

## Test plan
- Reset: with rst_n=0 mid-cycle, A_out, B_out, rd_valid and all registers read back 0 immediately. After release, a fetch of every address returns 16'h0000.
- Write/read: write 16'h00FF to r1 and 16'h000F to r2, then fetch addr_a=1, addr_b=2. Next cycle A_out=16'h00FF, B_out=16'h000F, rd_valid=1.
- Immediate: r3=16'hFFF1, addr_a=3, mb_select=1, const_in=16'h000F. Result A_out=16'hFFF1, B_out=16'h000F, with r-port B ignored.
- Hold: after a fetch of A_out=16'h7FFF, drive rd_en=0 for 3 cycles while changing addresses and writing the sourced register. A_out stays 16'h7FFF and rd_valid=0.
- Collision: r4=16'h0001, then on one edge write 16'h0000 to r4 with addr_a=4, rd_en=1. Required A_out: 16'h0000 with WRITE_BYPASS_EN, 16'h0001 without. The next fetch of r4 returns 16'h0000 in both builds.
- Reset mid-write: assert rst_n=0 before the edge of a write of 16'hABCD to r5. After release, r5 reads 16'h0000.

Source files
------------

// File: rtl/eu_register_file.sv
// -----------------------------------------------------------------------------
// eu_register_file
//
// General-purpose register file feeding the execution unit's arithmetic stage.
// Holds DEPTH = 2**ADDR_WIDTH registers of BUS_WIDTH bits. There are two read
// ports, which produce the registered operands A_out/B_out, and one writeback
// port, which captures the arithmetic unit's data_out.
//
// Optional feature macro: WRITE_BYPASS_EN
//   defined   : a fetch that collides with a same-edge write of the same
//               register returns the new (written) value.
//   undefined : such a fetch returns the pre-write contents. The write still
//               completes.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst_n      in   asynchronous active-low reset; clears all state
//   wr_en      in   writeback enable
//   wr_addr    in   [ADDR_WIDTH] writeback destination register
//   wr_data    in   [BUS_WIDTH]  writeback data
//   rd_en      in   operand fetch enable; when low, A_out/B_out hold
//   addr_a     in   [ADDR_WIDTH] source register for operand A
//   addr_b     in   [ADDR_WIDTH] source register for operand B
//   mb_select  in   1 selects const_in as operand B instead of regs[addr_b]
//   const_in   in   [BUS_WIDTH]  immediate operand
//   A_out      out  [BUS_WIDTH]  registered operand A
//   B_out      out  [BUS_WIDTH]  registered operand B
//   rd_valid   out  high for one cycle after each cycle with rd_en=1
// -----------------------------------------------------------------------------
module eu_register_file #(
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BUS_WIDTH-1:0]  wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  mb_select,
    input  logic [BUS_WIDTH-1:0]  const_in,
    output logic [BUS_WIDTH-1:0]  A_out,
    output logic [BUS_WIDTH-1:0]  B_out,
    output logic                  rd_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Flattened view of every register, used by the read multiplexers.
    logic [DEPTH-1:0][BUS_WIDTH-1:0] regs_q;

    logic [BUS_WIDTH-1:0] a_out_reg;
    logic [BUS_WIDTH-1:0] b_out_reg;
    logic                 rd_valid_reg;
    logic [BUS_WIDTH-1:0] a_out_next;
    logic [BUS_WIDTH-1:0] b_out_next;

    // The storage is built from flops rather than RAM, because reset must
    // clear every register at once.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic [BUS_WIDTH-1:0] data_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (wr_en && (wr_addr == ADDR_WIDTH'(gi))) begin
                    data_reg <= wr_data;
                end
            end

            assign regs_q[gi] = data_reg;
        end
    endgenerate

    // Operand selection. Without bypass, a same-edge write is invisible to
    // the fetch, because regs_q still holds the pre-write value.
    always_comb begin
        a_out_next = regs_q[addr_a];
        b_out_next = mb_select ? const_in : regs_q[addr_b];
`ifdef WRITE_BYPASS_EN
        // Forward the writeback value so that a dependent instruction can
        // issue right behind its producer. Operand B is forwarded only when
        // it actually comes from the register file.
        if (wr_en && (wr_addr == addr_a)) begin
            a_out_next = wr_data;
        end
        if (wr_en && !mb_select && (wr_addr == addr_b)) begin
            b_out_next = wr_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out_reg    <= '0;
            b_out_reg    <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
            if (rd_en) begin
                a_out_reg <= a_out_next;
                b_out_reg <= b_out_next;
            end
        end
    end

    assign A_out    = a_out_reg;
    assign B_out    = b_out_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_eu_register_file.sv
// -----------------------------------------------------------------------------
// tb_eu_register_file
//
// Directed, self-checking bench for eu_register_file. It follows the test
// plan: reset, write/read, immediate operand, hold, collision (expectation
// depends on WRITE_BYPASS_EN), register 0, back-to-back fetches and reset
// during a write. Inputs change on the falling edge. Outputs are sampled
// 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_eu_register_file;

    localparam int BW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic          mb_select;
    logic [BW-1:0] const_in;
    logic [BW-1:0] A_out;
    logic [BW-1:0] B_out;
    logic          rd_valid;

    int errors = 0;
    int checks = 0;

    eu_register_file #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .mb_select (mb_select),
        .const_in  (const_in),
        .A_out     (A_out),
        .B_out     (B_out),
        .rd_valid  (rd_valid)
    );

    always #5 clk = ~clk;

    // Watchdog so that the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock cycle: drive on the falling edge, then sample just after the
    // following rising edge.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [BW-1:0] wd,
                        input logic re, input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                        input logic mb, input logic [BW-1:0] ci);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; addr_a = aa; addr_b = ab; mb_select = mb; const_in = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    logic [BW-1:0] coll_exp;

    initial begin
        rst_n = 1'b0;
        wr_en = 0; wr_addr = '0; wr_data = '0; rd_en = 0;
        addr_a = '0; addr_b = '0; mb_select = 0; const_in = '0;

        // ---------------- power-on reset ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("por_a", A_out, 16'h0000);
        chk("por_b", B_out, 16'h0000);
        chk("por_valid", {15'd0, rd_valid}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- write / read ----------------
        step(1, 3'd1, 16'h00FF, 0, 3'd0, 3'd0, 0, 16'h0);
        step(1, 3'd2, 16'h000F, 0, 3'd0, 3'd0, 0, 16'h0);
        step(0, 3'd0, 16'h0000, 1, 3'd1, 3'd2, 0, 16'h0);
        chk("wr_rd_a", A_out, 16'h00FF);
        chk("wr_rd_b", B_out, 16'h000F);
        chk("wr_rd_valid", {15'd0, rd_valid}, 16'h0001);
        idle();
        chk("idle_valid", {15'd0, rd_valid}, 16'h0000);
        chk("idle_a_hold", A_out, 16'h00FF);

        // ---------------- immediate operand ----------------
        // addr_b points at r1 (00FF), so a missing const select would be visible.
        step(1, 3'd3, 16'hFFF1, 0, 3'd0, 3'd0, 0, 16'h0);
        step(0, 3'd0, 16'h0000, 1, 3'd3, 3'd1, 1, 16'h000F);
        chk("imm_a", A_out, 16'hFFF1);
        chk("imm_b", B_out, 16'h000F);

        // ---------------- hold ----------------
        step(1, 3'd6, 16'h7FFF, 0, 3'd0, 3'd0, 0, 16'h0);
        step(0, 3'd0, 16'h0000, 1, 3'd6, 3'd6, 0, 16'h0);
        chk("hold_fetch_a", A_out, 16'h7FFF);
        step(1, 3'd6, 16'h1234, 0, 3'd1, 3'd2, 0, 16'h0);
        chk("hold1_a", A_out, 16'h7FFF);
        chk("hold1_valid", {15'd0, rd_valid}, 16'h0000);
        step(1, 3'd6, 16'h4321, 0, 3'd2, 3'd3, 1, 16'hAAAA);
        chk("hold2_a", A_out, 16'h7FFF);
        chk("hold2_b", B_out, 16'h7FFF);
        step(0, 3'd0, 16'h0000, 0, 3'd3, 3'd1, 0, 16'h0);
        chk("hold3_a", A_out, 16'h7FFF);
        chk("hold3_valid", {15'd0, rd_valid}, 16'h0000);

        // ---------------- collision ----------------
        step(1, 3'd4, 16'h0001, 0, 3'd0, 3'd0, 0, 16'h0);
        step(1, 3'd4, 16'h0000, 1, 3'd4, 3'd4, 0, 16'h0);
`ifdef WRITE_BYPASS_EN
        coll_exp = 16'h0000;
`else
        coll_exp = 16'h0001;
`endif
        chk("coll_a", A_out, coll_exp);
        chk("coll_b", B_out, coll_exp);
        step(0, 3'd0, 16'h0000, 1, 3'd4, 3'd4, 0, 16'h0);
        chk("coll_next_a", A_out, 16'h0000);
        chk("coll_next_b", B_out, 16'h0000);

        // ---------------- register 0 is writable ----------------
        step(1, 3'd0, 16'h5A5A, 0, 3'd0, 3'd0, 0, 16'h0);
        step(0, 3'd0, 16'h0000, 1, 3'd0, 3'd0, 0, 16'h0);
        chk("r0_a", A_out, 16'h5A5A);
        chk("r0_b", B_out, 16'h5A5A);

        // ---------------- back-to-back fetches ----------------
        step(0, 3'd0, 16'h0000, 1, 3'd1, 3'd2, 0, 16'h0);
        chk("b2b1_a", A_out, 16'h00FF);
        chk("b2b1_valid", {15'd0, rd_valid}, 16'h0001);
        step(0, 3'd0, 16'h0000, 1, 3'd2, 3'd3, 0, 16'h0);
        chk("b2b2_a", A_out, 16'h000F);
        chk("b2b2_b", B_out, 16'hFFF1);
        chk("b2b2_valid", {15'd0, rd_valid}, 16'h0001);

        // ---------------- reset in the middle of a write ----------------
        // Outputs are non-zero here (A=000F, B=FFF1).
        @(negedge clk);
        wr_en = 1; wr_addr = 3'd5; wr_data = 16'hABCD;
        rd_en = 0; mb_select = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a", A_out, 16'h0000);
        chk("arst_b", B_out, 16'h0000);
        chk("arst_valid", {15'd0, rd_valid}, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        wr_en = 0;
        rst_n = 1'b1;

        // Every register must read back zero, including r5 and previously written ones.
        for (int i = 0; i < (1 << AW); i++) begin
            step(0, 3'd0, 16'h0000, 1, AW'(i), AW'(i), 0, 16'h0);
            chk($sformatf("clr_r%0d_a", i), A_out, 16'h0000);
            chk($sformatf("clr_r%0d_b", i), B_out, 16'h0000);
        end
        chk("clr_valid", {15'd0, rd_valid}, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
